axis_upsize_packer: RTL and testbench
=====================================

# axis_upsize_packer

Parametrised single-clock AXI-Stream width up-converter: packs RATIO input beats of IN_W bits into one output beat of IN_W*RATIO bits, with packet-aware flush on tlast, tkeep regeneration, per-packet byte length and packet/error counters. It is the next-generation replacement for the fixed 64-to-128 bridges, and sits after the rx CDC FIFOs, where source and sink already share one clock.

## Interface
- IN_W, 64: input data width in bits, multiple of 8.
- RATIO, 2: beats per output word; legal values 2, 4, 8.
- LEN_W, 16: width of the packet byte-length output.

- axis_uclk  in  1  stream clock; all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset, synchronously deasserted upstream.
- s_axis_tdata  in  IN_W  input data.
- s_axis_tkeep  in  IN_W/8  byte enables; all-ones on non-last beats, low-aligned contiguous on last.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  IN_W*RATIO  packed data.
- m_axis_tkeep  out  IN_W*RATIO/8  packed byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tready  in  1  output ready.
- m_pkt_bytes  out  LEN_W  packet byte count; valid with m_axis_tlast.
- CntClr  in  1  synchronous clear of all counters.
- RxPkg_Cnt  out  32  input packets accepted.
- TxPkg_Cnt  out  32  output packets delivered.
- KeepErr_Cnt  out  32  beats with illegal tkeep.

## Operation
- Input handshake: beat accepted when s_axis_tvalid & s_axis_tready. s_axis_tready = ~m_axis_tvalid | m_axis_tready (registered-output free or draining); no combinational path from s_axis_tvalid.
- Lane index idx (0..RATIO-1), reset 0. Accepted beat written to lane idx; lane 0 occupies the most significant IN_W bits, lane RATIO-1 the least.
- Two states: PACK (idx counts up) and implicit flush. Word completes when idx = RATIO-1 or s_axis_tlast; on completion the accumulator, its keep, and tlast move to the output register, idx returns to 0, accumulator keep cleared.
- Lanes not written before a tlast flush carry data 0 and keep 0.
- Keep per lane: input tkeep placed in lane's keep slice with lane 0 in MSBs.
- Byte count: running sum of popcount(s_axis_tkeep) over the packet, LEN_W wide, wraps modulo 2^LEN_W; registered to m_pkt_bytes with the tlast word, held until next tlast word; 0 while not on a tlast word.
- Illegal tkeep: non-last beat not all-ones, or last beat not of form 2^k-1 (k>=1). Beat still packed as given; KeepErr_Cnt increments.
- Counters: RxPkg_Cnt on accepted beat with tlast; TxPkg_Cnt on m_axis_tvalid & m_axis_tready & m_axis_tlast. Wrap 32'hFFFFFFFF to 0. CntClr has priority over increment in the same cycle.
- m_axis_tvalid holds, with data stable, until m_axis_tready.

## Timing
- Reset values: s_axis_tready 1 (output empty), m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, m_axis_tkeep 0, m_pkt_bytes 0, all counters 0, idx 0.
- Latency: completing beat accepted in cycle N -> m_axis_tvalid high at N+1.
- Throughput: one input beat per cycle with m_axis_tready held high; output valid one cycle in RATIO for full-length packets.
- Back-to-back packets: first beat of packet P+1 accepted the cycle after P's tlast beat; no bubble.
- Simultaneous output drain and new completion: output register reloaded same edge, m_axis_tvalid stays 1.
- Reset mid-packet: partial word and byte count discarded; output register cleared.

## Configuration
- AXIS_BYTE_SWAP_EN defined: each input beat byte-reversed within its IN_W lane (byte 0 to byte IN_W/8-1) before packing; the lane's keep bits reversed identically. Not defined: bytes packed in natural order. Byte count and error check use unswapped s_axis_tkeep in both cases.

## Test plan
- IN_W=64, RATIO=2, 4-beat packet, keep 0xFF, last keep 0x0F -> two outputs; second keep 0xFFF0... i.e. 16'hFF0F, tlast, m_pkt_bytes=28.
- RATIO=4, single-beat packet keep 0x07 -> one output, keep 32'h0700_0000, lanes 1-3 data 0, m_pkt_bytes=3, RxPkg_Cnt=TxPkg_Cnt=1.
- Random m_axis_tready (50%) over 1000 random packets -> reassembled byte stream matches scoreboard, no loss/duplication, counters equal packet count.
- Non-last beat keep 0x7F -> KeepErr_Cnt=1, data still delivered.
- Assert Rst_n low after 3 of 5 beats -> all outputs to reset values; next packet output correct, no stale lanes.
- With AXIS_BYTE_SWAP_EN, input 64'h0011223344556677 keep 0xFF, tlast, RATIO=2 -> upper lane 64'h7766554433221100, m_axis_tkeep 16'hFF00.

Source files
------------

// File: rtl/axis_upsize_packer.sv
// axis_upsize_packer: single-clock AXI-Stream width up-converter.
// Packs RATIO beats of IN_W bits into one IN_W*RATIO output word.
// Lane 0 of each word sits in the most significant IN_W bits.
// A tlast beat flushes a partial word; unwritten lanes carry data 0 and keep 0.
// The block also regenerates tkeep, reports per-packet byte length, and keeps
// packet and tkeep-error counters.
// Optional build macro AXIS_BYTE_SWAP_EN byte-reverses each input beat within
// its lane, together with its keep bits.
module axis_upsize_packer #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned RATIO = 2,
  parameter int unsigned LEN_W = 16
) (
  input  logic                      axis_uclk,
  input  logic                      Rst_n,
  input  logic [IN_W-1:0]           s_axis_tdata,
  input  logic [IN_W/8-1:0]         s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [IN_W*RATIO-1:0]     m_axis_tdata,
  output logic [IN_W*RATIO/8-1:0]   m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [LEN_W-1:0]          m_pkt_bytes,
  input  logic                      CntClr,
  output logic [31:0]               RxPkg_Cnt,
  output logic [31:0]               TxPkg_Cnt,
  output logic [31:0]               KeepErr_Cnt
);

  localparam int unsigned KB     = IN_W / 8;
  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned OUT_KB = OUT_W / 8;
  localparam int unsigned IDX_W  = $clog2(RATIO);

  logic [IDX_W-1:0]  idx;
  logic [OUT_W-1:0]  accData;
  logic [OUT_KB-1:0] accKeep;
  logic [OUT_W-1:0]  mergedData;
  logic [OUT_KB-1:0] mergedKeep;
  logic [LEN_W-1:0]  byteCnt;
  logic [LEN_W-1:0]  byteSum;
  logic [IN_W-1:0]   laneData;
  logic [KB-1:0]     laneKeep;
  logic              accept;
  logic              complete;
  logic              keepErr;

  // Upstream may push whenever the output register is empty or draining this cycle
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign complete      = accept & (s_axis_tlast | (idx == IDX_W'(RATIO - 1)));

`ifdef AXIS_BYTE_SWAP_EN
  // Byte-reverse the beat and its keep bits within the lane
  always_comb begin
    laneData = '0;
    laneKeep = '0;
    for (int b = 0; b < int'(KB); b++) begin
      laneData[b*8 +: 8] = s_axis_tdata[(int'(KB) - 1 - b)*8 +: 8];
      laneKeep[b]        = s_axis_tkeep[int'(KB) - 1 - b];
    end
  end
`else
  // Natural byte order
  assign laneData = s_axis_tdata;
  assign laneKeep = s_axis_tkeep;
`endif

  // Running packet byte count including the current beat (always unswapped keep)
  always_comb begin
    byteSum = byteCnt;
    for (int b = 0; b < int'(KB); b++) begin
      byteSum = byteSum + LEN_W'(s_axis_tkeep[b]);
    end
  end

  // Non-last beats must be all-ones; last beats must be low-aligned and non-empty
  always_comb begin
    keepErr = 1'b0;
    if (s_axis_tlast) begin
      keepErr = (s_axis_tkeep == '0) | ((s_axis_tkeep & (s_axis_tkeep + KB'(1))) != '0);
    end else begin
      keepErr = ~(&s_axis_tkeep);
    end
  end

  // Accumulator with the incoming beat dropped into lane idx
  always_comb begin
    int unsigned laneSel;
    laneSel    = (RATIO - 1) - 32'(idx);
    mergedData = accData;
    mergedKeep = accKeep;
    mergedData[laneSel*IN_W +: IN_W] = laneData;
    mergedKeep[laneSel*KB +: KB]     = laneKeep;
  end

  // Lane index, accumulator and byte counter
  always_ff @(posedge axis_uclk or negedge Rst_n) begin
    if (!Rst_n) begin
      idx     <= '0;
      accData <= '0;
      accKeep <= '0;
      byteCnt <= '0;
    end else if (accept) begin
      if (complete) begin
        idx     <= '0;
        accData <= '0;
        accKeep <= '0;
      end else begin
        idx     <= idx + IDX_W'(1);
        accData <= mergedData;
        accKeep <= mergedKeep;
      end
      byteCnt <= s_axis_tlast ? '0 : byteSum;
    end
  end

  // Output register: load on word completion, release on downstream ready
  always_ff @(posedge axis_uclk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_pkt_bytes   <= '0;
    end else if (complete) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tdata  <= mergedData;
      m_axis_tkeep  <= mergedKeep;
      m_pkt_bytes   <= s_axis_tlast ? byteSum : '0;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Statistics counters; clear wins over increment
  always_ff @(posedge axis_uclk or negedge Rst_n) begin
    if (!Rst_n) begin
      RxPkg_Cnt   <= '0;
      TxPkg_Cnt   <= '0;
      KeepErr_Cnt <= '0;
    end else if (CntClr) begin
      RxPkg_Cnt   <= '0;
      TxPkg_Cnt   <= '0;
      KeepErr_Cnt <= '0;
    end else begin
      if (accept & s_axis_tlast) begin
        RxPkg_Cnt <= RxPkg_Cnt + 32'd1;
      end
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast) begin
        TxPkg_Cnt <= TxPkg_Cnt + 32'd1;
      end
      if (accept & keepErr) begin
        KeepErr_Cnt <= KeepErr_Cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_upsize_packer.sv
// Randomized scoreboard bench for axis_upsize_packer (IN_W=64, RATIO=2).
module tb_axis_upsize_packer;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned RATIO = 2;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned KB    = IN_W / 8;
  localparam int unsigned OW    = IN_W * RATIO;
  localparam int unsigned OKB   = OW / 8;

  logic              axis_uclk = 1'b0;
  logic              Rst_n;
  logic [IN_W-1:0]   s_axis_tdata;
  logic [KB-1:0]     s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [OW-1:0]     m_axis_tdata;
  logic [OKB-1:0]    m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [LEN_W-1:0]  m_pkt_bytes;
  logic              CntClr;
  logic [31:0]       RxPkg_Cnt;
  logic [31:0]       TxPkg_Cnt;
  logic [31:0]       KeepErr_Cnt;

  always #5 axis_uclk = ~axis_uclk;

  axis_upsize_packer #(.IN_W(IN_W), .RATIO(RATIO), .LEN_W(LEN_W)) dut (
    .axis_uclk(axis_uclk), .Rst_n(Rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_pkt_bytes(m_pkt_bytes),
    .CntClr(CntClr), .RxPkg_Cnt(RxPkg_Cnt), .TxPkg_Cnt(TxPkg_Cnt),
    .KeepErr_Cnt(KeepErr_Cnt)
  );

  typedef struct {
    logic [OW-1:0]    d;
    logic [OKB-1:0]   k;
    logic             l;
    logic [LEN_W-1:0] n;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   expRx    = 0;
  int   expErr   = 0;
  int   stalls   = 0;
  bit   rdyAlways = 1'b1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic bit illegal_keep(input logic [KB-1:0] k, input bit last);
    if (!last) return k != '1;
    for (int n = 1; n <= int'(KB); n++) begin
      if (k == KB'((1 << n) - 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one beat and hold it until the DUT takes it
  task automatic drive_beat(input logic [IN_W-1:0] d, input logic [KB-1:0] k, input logic l);
    int t;
    @(negedge axis_uclk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    t = 0;
    forever begin
      #2;
      if (s_axis_tready) break;
      stalls++;
      t++;
      if (t > 1000) begin
        checks++;
        failures++;
        $display("FAIL input_timeout: s_axis_tready stuck at 0 for %0d cycles", t);
        break;
      end
      @(negedge axis_uclk);
    end
    @(posedge axis_uclk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  // Build a packet, push the words the spec predicts, then drive its first 'cut' beats
  task automatic send_pkt(input int nb, input logic [KB-1:0] lastKeep, input int errBeat, input int cut);
    logic [IN_W-1:0] d[$];
    logic [KB-1:0]   k[$];
    int   sum;
    int   src;
    int   pos;
    int   bi;
    exp_t e;
    sum = 0;
    for (int i = 0; i < nb; i++) begin
      d.push_back({$urandom, $urandom});
      if (i == nb - 1)       k.push_back(lastKeep);
      else if (i == errBeat) k.push_back(KB'(8'h7F));
      else                   k.push_back('1);
      sum += $countones(k[i]);
      if (i < cut && illegal_keep(k[i], i == nb - 1)) expErr++;
    end
    for (int w = 0; w * int'(RATIO) < nb; w++) begin
      if (cut < nb && (w + 1) * int'(RATIO) > cut) break;
      e.d = '0;
      e.k = '0;
      for (int j = 0; j < int'(RATIO); j++) begin
        bi = w * int'(RATIO) + j;
        if (bi < nb) begin
          for (int b = 0; b < int'(KB); b++) begin
`ifdef AXIS_BYTE_SWAP_EN
            src = int'(KB) - 1 - b;
`else
            src = b;
`endif
            pos = (int'(RATIO) - 1 - j) * int'(KB) + b;
            e.d[pos*8 +: 8] = d[bi][src*8 +: 8];
            e.k[pos]        = k[bi][src];
          end
        end
      end
      e.l = ((w + 1) * int'(RATIO) >= nb);
      e.n = e.l ? LEN_W'(sum) : '0;
      expQ.push_back(e);
    end
    if (cut >= nb) expRx++;
    for (int i = 0; i < cut; i++) drive_beat(d[i], k[i], i == nb - 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expQ.size() != 0 && t < 5000) begin
      @(negedge axis_uclk);
      t++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d words still expected", expQ.size());
      expQ.delete();
    end
    repeat (3) @(negedge axis_uclk);
  endtask

  task automatic check_counters(input string tag);
    check32({tag, "_RxPkg_Cnt"}, RxPkg_Cnt, 32'(expRx));
    check32({tag, "_TxPkg_Cnt"}, TxPkg_Cnt, 32'(expRx));
    check32({tag, "_KeepErr_Cnt"}, KeepErr_Cnt, 32'(expErr));
  endtask

  // Monitor: random or constant back-pressure, compare each delivered word
  initial begin
    exp_t e;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge axis_uclk);
      m_axis_tready = rdyAlways ? 1'b1 : 1'($urandom % 2);
      #2;
      if (Rst_n && m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL out_word: got data=%h keep=%h last=%b with none expected",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast);
        end else begin
          e = expQ.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tlast !== e.l ||
              m_pkt_bytes !== e.n) begin
            failures++;
            $display("FAIL out_word: got data=%h keep=%h last=%b bytes=%0d expected data=%h keep=%h last=%b bytes=%0d",
                     m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_pkt_bytes, e.d, e.k, e.l, e.n);
          end
        end
      end
    end
  end

  initial begin
    Rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    CntClr        = 1'b0;
    #12;
    check32("rst_s_tready", 32'(s_axis_tready), 32'd1);
    check32("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check32("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check32("rst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    check32("rst_m_tdata_or", 32'(|m_axis_tdata), 32'd0);
    check32("rst_pkt_bytes", 32'(m_pkt_bytes), 32'd0);
    check_counters("rst");
    @(negedge axis_uclk);
    Rst_n = 1'b1;
    repeat (2) @(negedge axis_uclk);

    // Directed packets with the sink always ready: no input stalls allowed
    stalls = 0;
    send_pkt(4, KB'(8'h0F), -1, 4);   // keep 16'hFF0F, 28 bytes
    send_pkt(1, KB'(8'h07), -1, 1);   // keep 16'h0700, 3 bytes
    send_pkt(3, KB'(8'hFF), 0, 3);    // non-last keep 0x7F error
    send_pkt(2, KB'(8'h01), -1, 2);
    drain();
    check32("no_bubble_stalls", 32'(stalls), 32'd0);
    check_counters("directed");

    // Reset in the middle of a 5-beat packet after 3 beats
    send_pkt(5, KB'(8'hFF), -1, 3);
    drain();
    @(negedge axis_uclk);
    Rst_n = 1'b0;
    #1;
    expRx  = 0;
    expErr = 0;
    check32("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check32("midrst_m_tkeep", 32'(m_axis_tkeep), 32'd0);
    check32("midrst_pkt_bytes", 32'(m_pkt_bytes), 32'd0);
    check_counters("midrst");
    @(negedge axis_uclk);
    Rst_n = 1'b1;
    send_pkt(1, KB'(8'h3F), -1, 1);
    send_pkt(3, KB'(8'h7F), -1, 3);
    drain();
    check_counters("postrst");

    // Random packets with random back-pressure
    rdyAlways = 1'b0;
    for (int p = 0; p < 1000; p++) begin
      int nb;
      int errBeat;
      logic [KB-1:0] lk;
      nb = $urandom_range(1, 3 * RATIO + 1);
      lk = KB'((1 << $urandom_range(1, KB)) - 1);
      if ($urandom % 16 == 0) lk = KB'($urandom_range(1, (1 << KB) - 1));
      errBeat = ($urandom % 20 == 0 && nb > 1) ? int'($urandom_range(0, nb - 2)) : -1;
      send_pkt(nb, lk, errBeat, nb);
      if ($urandom % 8 == 0) @(negedge axis_uclk);
    end
    drain();
    check_counters("random");

    // Counter clear
    @(negedge axis_uclk);
    CntClr = 1'b1;
    @(negedge axis_uclk);
    CntClr = 1'b0;
    expRx  = 0;
    expErr = 0;
    check_counters("cntclr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
